// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: RX/TX byte FIFOs, sticky overflow flags,
// occupancy counts and a registered level interrupt behind a 4-word window.

module uart_mmio_fifo_buf #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_mmio_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  wbe,
    input  logic        rd_en,
    output logic [31:0] dout,
    input  logic [7:0]  data_out,
    input  logic        data_out_valid,
    output logic        data_out_ready,
    output logic [7:0]  data_in,
    output logic        data_in_valid,
    input  logic        data_in_ready,
    output logic        irq
);
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    localparam logic [31:0] A_STATUS = BASE_ADDR;
    localparam logic [31:0] A_RXDATA = BASE_ADDR + 32'h4;
    localparam logic [31:0] A_TXDATA = BASE_ADDR + 32'h8;
    localparam logic [31:0] A_CTRL   = BASE_ADDR + 32'hC;

    logic [7:0]       rx_head;
    logic [7:0]       tx_head;
    logic [RX_CW-1:0] rx_count;
    logic [TX_CW-1:0] tx_count;
    logic             rx_full, rx_empty;
    logic             tx_full, tx_empty;
    logic             rx_pop, tx_push, tx_pop;
    logic             ctrl_wr;
    logic             rx_ovf_set, tx_ovf_set;
    logic             rx_overflow, tx_overflow;
    logic             rx_irq_en, tx_irq_en;
    logic [31:0]      status;
    logic             unused_bits;

    assign unused_bits = ^{din[31:8], wbe[3:1]};

    assign rx_pop     = rd_en && (addr == A_RXDATA) && !rx_empty;
    assign tx_push    = wbe[0] && (addr == A_TXDATA);
    assign tx_pop     = data_in_valid && data_in_ready;
    assign ctrl_wr    = wbe[0] && (addr == A_CTRL);
    assign rx_ovf_set = data_out_valid && rx_full && !rx_pop;
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;

    uart_mmio_fifo_buf #(.DEPTH(RX_DEPTH), .CW(RX_CW)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (data_out_valid),
        .pop   (rx_pop),
        .wdata (data_out),
        .rdata (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart_mmio_fifo_buf #(.DEPTH(TX_DEPTH), .CW(TX_CW)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (din[7:0]),
        .rdata (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign data_out_ready = 1'b1;
    assign data_in_valid  = !tx_empty;
    assign data_in        = tx_empty ? 8'h00 : tx_head;

    // Overflow set beats a same-cycle software clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overflow <= 1'b0;
            tx_overflow <= 1'b0;
            rx_irq_en   <= 1'b0;
            tx_irq_en   <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rx_irq_en <= din[0];
                tx_irq_en <= din[1];
            end
            if (rx_ovf_set) begin
                rx_overflow <= 1'b1;
            end else if (ctrl_wr && din[2]) begin
                rx_overflow <= 1'b0;
            end
            if (tx_ovf_set) begin
                tx_overflow <= 1'b1;
            end else if (ctrl_wr && din[3]) begin
                tx_overflow <= 1'b0;
            end
            irq <= (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty);
        end
    end

    assign status = {8'h00, 8'(tx_count), 8'(rx_count), 3'b000,
                     tx_overflow, tx_empty, rx_overflow, !rx_empty, !tx_full};

    always_comb begin
        dout = 32'h0;
        case (addr)
            A_STATUS: dout = status;
            A_RXDATA: dout = rx_empty ? 32'h0 : {24'h0, rx_head};
            A_CTRL:   dout = {30'h0, tx_irq_en, rx_irq_en};
            default:  dout = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: reset, RX ordering/overflow, TX flow
// control/overflow/wrap and interrupt timing against hand-computed values.

module tb_uart_mmio_fifo;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] STATUS = BASE;
    localparam logic [31:0] RXDATA = BASE + 32'h4;
    localparam logic [31:0] TXDATA = BASE + 32'h8;
    localparam logic [31:0] CTRL   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  wbe;
    logic        rd_en;
    logic [31:0] dout;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_mmio_fifo #(.BASE_ADDR(BASE), .RX_DEPTH(8), .TX_DEPTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr           (addr),
        .din            (din),
        .wbe            (wbe),
        .rd_en          (rd_en),
        .dout           (dout),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; din = d; wbe = 4'h1;
        tick();
        wbe = 4'h0; din = 32'h0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        #1;
        d = dout;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic rx_push(input logic [7:0] b);
        data_out = b; data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        cpu_write(CTRL, 32'h3);
        cpu_write(TXDATA, 32'h12);
        rx_push(8'h34);
        data_out = 8'h35; data_out_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (data_in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async_valid: got %b expected 0", data_in_valid);
        end
        data_out_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        peek(STATUS, r);
        tests_run++;
        if (r !== 32'h0000_0009) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected 00000009", r);
        end
        tests_run++;
        if ({irq, data_in_valid, data_in, data_out_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got irq=%b valid=%b data_in=%h ready=%b expected 0 0 00 1",
                     irq, data_in_valid, data_in, data_out_ready);
        end
        peek(CTRL, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %h expected 00000000", r);
        end
    endtask

    task automatic test_rx_order();
        logic [31:0] r;
        logic [7:0]  exp [3] = '{8'h41, 8'h42, 8'h43};
        rx_push(8'h41);
        peek(STATUS, r);
        tests_run++;
        if (r[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rx_latency_status: got bit1=%b expected 1", r[1]);
        end
        rx_push(8'h42);
        rx_push(8'h43);
        peek(STATUS, r);
        tests_run++;
        if (r[15:8] !== 8'd3) begin
            tests_failed++;
            $display("FAIL rx_count3: got %0d expected 3", r[15:8]);
        end
        for (int i = 0; i < 3; i++) begin
            cpu_read(RXDATA, r);
            tests_run++;
            if (r !== {24'h0, exp[i]}) begin
                tests_failed++;
                $display("FAIL rx_order[%0d]: got %h expected %h", i, r, exp[i]);
            end
        end
        cpu_read(RXDATA, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL rx_empty_read: got %h expected 00000000", r);
        end
        peek(STATUS, r);
        tests_run++;
        if (r[1] !== 1'b0 || r[15:8] !== 8'd0) begin
            tests_failed++;
            $display("FAIL rx_empty_status: got bit1=%b count=%0d expected 0 0", r[1], r[15:8]);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] r;
        logic [7:0]  exp [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h99};
        for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
        peek(STATUS, r);
        tests_run++;
        if (r[15:8] !== 8'd8 || r[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rx_ovf_set: got count=%0d ovf=%b expected 8 1", r[15:8], r[2]);
        end
        cpu_write(CTRL, 32'h4);
        peek(STATUS, r);
        tests_run++;
        if (r[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_ovf_clear: got %b expected 0", r[2]);
        end
        // pop and push on a full FIFO in the same cycle
        data_out = 8'h99; data_out_valid = 1'b1;
        addr = RXDATA; rd_en = 1'b1;
        #1;
        r = dout;
        tick();
        data_out_valid = 1'b0; rd_en = 1'b0;
        tests_run++;
        if (r !== 32'h10) begin
            tests_failed++;
            $display("FAIL rx_full_pop_data: got %h expected 00000010", r);
        end
        peek(STATUS, r);
        tests_run++;
        if (r[15:8] !== 8'd8 || r[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_full_push_pop: got count=%0d ovf=%b expected 8 0", r[15:8], r[2]);
        end
        // overflow set coincides with a software clear
        data_out = 8'hEE; data_out_valid = 1'b1;
        addr = CTRL; din = 32'h4; wbe = 4'h1;
        tick();
        data_out_valid = 1'b0; wbe = 4'h0; din = 32'h0;
        peek(STATUS, r);
        tests_run++;
        if (r[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rx_ovf_set_wins: got %b expected 1", r[2]);
        end
        cpu_write(CTRL, 32'h4);
        for (int i = 0; i < 8; i++) begin
            cpu_read(RXDATA, r);
            tests_run++;
            if (r !== {24'h0, exp[i]}) begin
                tests_failed++;
                $display("FAIL rx_ovf_drain[%0d]: got %h expected %h", i, r, exp[i]);
            end
        end
    endtask

    task automatic test_tx_flow();
        logic [31:0] r;
        data_in_ready = 1'b0;
        cpu_write(TXDATA, 32'h55);
        tests_run++;
        if (data_in_valid !== 1'b1 || data_in !== 8'h55) begin
            tests_failed++;
            $display("FAIL tx_latency: got valid=%b data=%h expected 1 55", data_in_valid, data_in);
        end
        cpu_write(TXDATA, 32'hAA);
        peek(STATUS, r);
        tests_run++;
        if (r[23:16] !== 8'd2 || r[3] !== 1'b0 || data_in !== 8'h55) begin
            tests_failed++;
            $display("FAIL tx_hold: got count=%0d empty=%b data=%h expected 2 0 55", r[23:16], r[3], data_in);
        end
        data_in_ready = 1'b1;
        tick();
        data_in_ready = 1'b0;
        tests_run++;
        if (data_in_valid !== 1'b1 || data_in !== 8'hAA) begin
            tests_failed++;
            $display("FAIL tx_pop1: got valid=%b data=%h expected 1 aa", data_in_valid, data_in);
        end
        data_in_ready = 1'b1;
        tick();
        data_in_ready = 1'b0;
        peek(STATUS, r);
        tests_run++;
        if (data_in_valid !== 1'b0 || data_in !== 8'h00 || r[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_pop2: got valid=%b data=%h empty=%b expected 0 00 1", data_in_valid, data_in, r[3]);
        end
    endtask

    task automatic test_tx_overflow_wrap();
        logic [31:0] r;
        logic [7:0]  exp [8] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h69};
        int          bad;
        data_in_ready = 1'b0;
        for (int i = 0; i < 8; i++) cpu_write(TXDATA, 32'h60 + i);
        peek(STATUS, r);
        tests_run++;
        if (r[0] !== 1'b0 || r[23:16] !== 8'd8) begin
            tests_failed++;
            $display("FAIL tx_full: got not_full=%b count=%0d expected 0 8", r[0], r[23:16]);
        end
        cpu_write(TXDATA, 32'h68);
        peek(STATUS, r);
        tests_run++;
        if (r[4] !== 1'b1 || r[23:16] !== 8'd8) begin
            tests_failed++;
            $display("FAIL tx_ovf_set: got ovf=%b count=%0d expected 1 8", r[4], r[23:16]);
        end
        cpu_write(CTRL, 32'h8);
        // write into a full FIFO while the head is leaving
        data_in_ready = 1'b1;
        cpu_write(TXDATA, 32'h69);
        data_in_ready = 1'b0;
        peek(STATUS, r);
        tests_run++;
        if (r[4] !== 1'b0 || r[23:16] !== 8'd8) begin
            tests_failed++;
            $display("FAIL tx_full_push_pop: got ovf=%b count=%0d expected 0 8", r[4], r[23:16]);
        end
        data_in_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (data_in !== exp[i] || data_in_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL tx_drain[%0d]: got %h valid=%b expected %h", i, data_in, data_in_valid, exp[i]);
            end
            tick();
        end
        data_in_ready = 1'b0;
        tests_run++;
        if (data_in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_drained: got valid=%b expected 0", data_in_valid);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cpu_write(TXDATA, 32'h80 + i);
            if (i % 2 == 1) cpu_write(TXDATA, 32'hC0 + i);
            if (data_in !== 8'(8'h80 + i)) bad++;
            data_in_ready = 1'b1;
            tick();
            if (i % 2 == 1) begin
                if (data_in !== 8'(8'hC0 + i)) bad++;
                tick();
            end
            data_in_ready = 1'b0;
        end
        tests_run++;
        if (bad !== 0 || data_in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_wrap_order: got %0d wrong bytes valid=%b expected 0 0", bad, data_in_valid);
        end
    endtask

    task automatic test_irq();
        logic [31:0] r;
        data_in_ready = 1'b0;
        cpu_write(CTRL, 32'h3);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_latency: got %b expected 0", irq);
        end
        tick();
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_tx_empty: got %b expected 1", irq);
        end
        cpu_write(TXDATA, 32'h5A);
        tick();
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_tx_busy: got %b expected 0", irq);
        end
        rx_push(8'h77);
        tick();
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_rx: got %b expected 1", irq);
        end
        cpu_read(RXDATA, r);
        tests_run++;
        if (r !== 32'h77) begin
            tests_failed++;
            $display("FAIL irq_rx_data: got %h expected 00000077", r);
        end
        tick();
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_cleared: got %b expected 0", irq);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr = 32'h0; din = 32'h0; wbe = 4'h0; rd_en = 1'b0;
        data_out = 8'h0; data_out_valid = 1'b0; data_in_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_reset();
        test_rx_order();
        test_rx_overflow();
        test_tx_flow();
        test_tx_overflow_wrap();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
